// File: rtl/key_pulse_array.sv
// rtl/key_pulse_array.sv - per-key debounce, press pulse and auto-repeat array
module key_pulse_array #(
    parameter int NUM_KEYS        = 4,
    parameter int PULSE_LENGTH    = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_WIDTH       = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                repeat_en,
    output logic [NUM_KEYS-1:0] pulse,
    output logic [NUM_KEYS-1:0] held,
    output logic                any_pulse
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_PULSE    = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PUL_LAST = CNT_WIDTH'(PULSE_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] ks_q, ks_d;
    logic [NUM_KEYS-1:0] pulse_nxt;
    logic                any_pulse_q, any_pulse_d;

    always_comb begin
        sync1_d     = key;
        ks_d        = sync1_q;
        any_pulse_d = |pulse_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            ks_q        <= '0;
            any_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            ks_q        <= ks_d;
            any_pulse_q <= any_pulse_d;
        end
    end

    assign any_pulse = any_pulse_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [2:0]           state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 rpt_q, rpt_d;
        logic                 pulse_q, pulse_d;
        logic                 held_q, held_d;
        logic                 ks;

        assign ks = ks_q[i];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                rpt_q   <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rpt_q   <= rpt_d;
                pulse_q <= pulse_d;
                held_q  <= held_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rpt_d   = rpt_q;
            case (state_q)
                S_IDLE: begin
                    if (ks) begin
                        state_d = S_DEBOUNCE;
                        cnt_d   = '0;
                        rpt_d   = 1'b0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!ks) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_PULSE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == PUL_LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HOLD: begin
                    // Parking the count at zero makes a later enable start a full delay
                    if (!ks) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end else if (!repeat_en) begin
                        cnt_d = '0;
                    end else if (cnt_q == (rpt_q ? PER_LAST : DLY_LAST)) begin
                        state_d = S_PULSE;
                        cnt_d   = '0;
                        rpt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    if (ks) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rpt_d   = 1'b0;
                end
            endcase
        end

        always_comb begin
            pulse_d = (state_q == S_PULSE);
            held_d  = (state_q == S_HOLD) || (state_q == S_RELEASE);
        end

        assign pulse_nxt[i] = pulse_d;
        assign pulse[i]     = pulse_q;
        assign held[i]      = held_q;
    end

endmodule

// File: doc/key_pulse_array.md
KEY_PULSE_ARRAY -- requirements
Module: key_pulse_array

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, number of independent key channels (>=1).
REQ-002 The block SHALL have parameter PULSE_LENGTH, default 5, output pulse width in cycles (>=1).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, cycles a level must persist to be accepted (>=1).
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 16, hold cycles before the first auto-repeat pulse (>=1).
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 8, hold cycles between later auto-repeat pulses (>=1).
REQ-006 The block SHALL have parameter CNT_WIDTH, default 26, per-channel counter width; every cycle-count parameter SHALL be < 2^CNT_WIDTH.
REQ-007 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port key, input, NUM_KEYS, raw asynchronous buttons, 1 = pressed.
REQ-010 The block SHALL have port repeat_en, input, 1, 1 = auto-repeat enabled for all channels; sampled every cycle.
REQ-011 The block SHALL have port pulse, output, NUM_KEYS, per-channel press pulse.
REQ-012 The block SHALL have port held, output, NUM_KEYS, 1 while the channel is in HOLD or RELEASE.
REQ-013 The block SHALL have port any_pulse, output, 1, OR of all pulse bits.

Function
REQ-014 Each channel SHALL pass key through a 2-flop synchronizer; ks denotes the second flop output.
REQ-015 Each channel SHALL run an independent FSM {IDLE, DEBOUNCE, PULSE, HOLD, RELEASE} with counter cnt and flag rpt; the channels SHALL share no state.
REQ-016 IDLE: when ks=1, the channel SHALL go to DEBOUNCE with cnt=0 and rpt=0; otherwise it SHALL stay in IDLE.
REQ-017 DEBOUNCE: when ks=0, the channel SHALL go to IDLE; else when cnt=DEBOUNCE_CYCLES-1 it SHALL go to PULSE with cnt=0; else cnt SHALL increment.
REQ-018 PULSE: when cnt=PULSE_LENGTH-1, the channel SHALL go to HOLD with cnt=0; else cnt SHALL increment; key release SHALL NOT shorten the pulse.
REQ-019 HOLD: when ks=0, the channel SHALL go to RELEASE with cnt=0; else when repeat_en=1 and cnt=(rpt ? REPEAT_PERIOD : REPEAT_DELAY)-1, it SHALL go to PULSE with cnt=0 and rpt=1; else cnt SHALL increment (no wrap needed; the count is bounded by the parameters).
REQ-020 HOLD with repeat_en=0: cnt SHALL hold at 0 so that re-enabling repeat starts a full delay.
REQ-021 RELEASE: when ks=1, the channel SHALL return to HOLD with cnt=0 (a glitch is ignored, no new pulse); else when cnt=DEBOUNCE_CYCLES-1 it SHALL go to IDLE; else cnt SHALL increment.
REQ-022 ks=0 and a terminal count in the same cycle: ks=0 SHALL take priority in DEBOUNCE and HOLD.
REQ-023 Outputs SHALL be registered: pulse[i] SHALL be 1 exactly while channel i is in PULSE; held[i] SHALL be 1 in HOLD or RELEASE; any_pulse SHALL be registered alongside pulse.
REQ-024 Latency: for a clean press first sampled at edge 1, pulse SHALL rise DEBOUNCE_CYCLES+3 edges later and stay high for exactly PULSE_LENGTH cycles.
REQ-025 Each accepted press SHALL produce exactly one pulse, plus one per repeat interval while held with repeat_en=1.
REQ-026 Unused FSM encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 While reset=1, all synchronizers, states (IDLE), cnt, rpt, pulse, held and any_pulse SHALL be 0 immediately, independent of clock.
REQ-028 Reset asserted mid-pulse SHALL clear pulse at once; after release, a still-pressed key SHALL re-debounce and produce a new pulse.

Verification (NUM_KEYS=4, PULSE_LENGTH=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Clean press: key[0] high for 40 cycles, repeat_en=0 -> pulse[0] high at edges 8-10 only, held[0]=1 from edge 11 until release plus 4 cycles, any_pulse mirrors pulse[0].
REQ-030 Bounce: key[1] high 2 cycles, low 1, high 2 -> no pulse[1]; a later 6-cycle press -> exactly one 3-cycle pulse.
REQ-031 Auto-repeat: key[2] held 60 cycles, repeat_en=1 -> first pulse, then pulses starting 10 cycles after HOLD entry, then every 5+3 cycles; all 3 cycles wide.
REQ-032 Release glitch: key[0] held, then low 2 cycles during HOLD -> held stays 1, no extra pulse.
REQ-033 Simultaneous: key[0] and key[3] rise on the same edge -> identical, independent pulses; key[1] and key[2] stay 0.
REQ-034 Reset mid-pulse: assert reset between clock edges during pulse[0] -> all outputs 0 immediately; after deassert with key still high -> new pulse DEBOUNCE_CYCLES+3 edges later.
